image_io_ctrl: RTL

Host-side controller for the image downsampling processor's data memory. It loads a raw image byte stream into data memory and pulses `processor_start`. It then waits for the processor's completion `status` and streams the downsampled result back out. It owns the data-memory port whenever the processor is not running, and drives the ownership select for the external memory mux.

---
 rtl/img_pkg.sv | 8 +
 rtl/image_io_ctrl_if.sv | 25 ++
 rtl/image_io_ctrl.sv | 67 ++++++
 3 files changed

// File: rtl/img_pkg.sv
// img_pkg: shared state type and frame geometry defaults for the image downsampling system
package img_pkg;
  typedef enum logic [2:0] {LOAD, START, RUN, RD_REQ, RD_WAIT, SEND, DONE} io_state_t;
  localparam int ADDR_W = 19;
  localparam int DEF_IMG_BYTES = 65536;
  localparam int DEF_RESULT_BASE = 65536;
  localparam int DEF_RESULT_BYTES = 16384;
endpackage

// File: rtl/image_io_ctrl_if.sv
// image_io_ctrl_if: pixel streams, data-memory port and processor handshake of the host controller
interface image_io_ctrl_if #(parameter int ADDR_W = img_pkg::ADDR_W);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;
  logic [7:0]        mem_rd_data;
  logic              mem_owner;
  logic              processor_start;
  logic              proc_status;
  logic              frame_done;
  modport master (
    output in_valid, in_data, out_ready, mem_rd_data, proc_status,
    input  in_ready, out_valid, out_data, mem_addr, mem_wr_en, mem_wr_data, mem_owner, processor_start, frame_done
  );
  modport slave (
    input  in_valid, in_data, out_ready, mem_rd_data, proc_status,
    output in_ready, out_valid, out_data, mem_addr, mem_wr_en, mem_wr_data, mem_owner, processor_start, frame_done
  );
endinterface

// File: rtl/image_io_ctrl.sv
// image_io_ctrl: loads an image into data memory, starts the processor and streams the result back
module image_io_ctrl #(
  parameter int ADDR_W = img_pkg::ADDR_W,
  parameter int IMG_BYTES = img_pkg::DEF_IMG_BYTES,
  parameter int RESULT_BASE = img_pkg::DEF_RESULT_BASE,
  parameter int RESULT_BYTES = img_pkg::DEF_RESULT_BYTES
) (
  input logic clk,
  input logic RST,
  image_io_ctrl_if.slave io
);
  import img_pkg::*;
  if (RESULT_BASE + RESULT_BYTES > (1 << ADDR_W)) begin : g_range_chk
    $error("result region does not fit in the data-memory address space");
  end
  io_state_t         state;
  logic [ADDR_W-1:0] load_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic              status_q;
  logic [7:0]        out_q;
  logic              load_last;
  logic              rd_last;
  logic              rd_phase;
  assign load_last = load_cnt == ADDR_W'(IMG_BYTES - 1);
  assign rd_last = rd_cnt == ADDR_W'(RESULT_BYTES - 1);
  assign rd_phase = state inside {RD_REQ, RD_WAIT, SEND};
  assign io.in_ready = state == LOAD;
  assign io.mem_wr_en = (state == LOAD) & io.in_valid;
  assign io.mem_wr_data = io.mem_wr_en ? io.in_data : 8'h00;
  assign io.mem_addr = rd_phase ? ADDR_W'(RESULT_BASE) + rd_cnt : load_cnt;
  assign io.mem_owner = state inside {START, RUN};
  assign io.processor_start = state == START;
  assign io.out_valid = state == SEND;
  assign io.out_data = out_q;
  assign io.frame_done = state == DONE;
  // frame sequencing: load, start, wait for a fresh completion edge, then byte-wise readback
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= LOAD;
      load_cnt <= '0;
      rd_cnt <= '0;
      status_q <= 1'b0;
      out_q <= 8'h00;
    end else begin
      status_q <= io.proc_status;
      case (state)
        LOAD: if (io.in_valid) begin
          load_cnt <= load_last ? '0 : load_cnt + 1'b1;
          if (load_last) state <= START;
        end
        START: state <= RUN;
        RUN: if (io.proc_status & ~status_q) state <= RD_REQ;
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          out_q <= io.mem_rd_data;
          state <= SEND;
        end
        SEND: if (io.out_ready) begin
          rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
          state <= rd_last ? DONE : RD_REQ;
        end
        DONE: state <= LOAD;
        default: state <= LOAD;
      endcase
    end
  end
endmodule
